exception_ctrl: RTL

Exception/interrupt request generator that drives the CP0 exception port: `exception`, `cause`, `pc`, `eret`. It sits beside the ID stage and watches decoded syscall/break/teq and eret instructions plus one external interrupt line. It gates each request with the CP0 status masks, arbitrates between sources, and issues the single-cycle request to CP0. It then flushes the pipeline for a fixed drain window and selects the exception/return vector as the next PC.

---
 rtl/exception_ctrl_if.sv | 35 +++
 rtl/exception_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: ID-stage decode/status inputs and CP0/pipeline control outputs of exception_ctrl.
interface exception_ctrl_if;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 5;

  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic               pipe_stall;
  logic               is_syscall;
  logic               is_break;
  logic               is_teq_trap;
  logic               is_eret;
  logic               ext_irq;
  logic [XLEN-1:0]    status;
  logic               cp0_mtc0;
  logic               exception;
  logic [CAUSE_W-1:0] cause;
  logic [XLEN-1:0]    epc;
  logic               eret;
  logic               flush;
  logic               pc_redirect;
  logic               busy;

  modport master (
    output id_valid, id_pc, pipe_stall, is_syscall, is_break, is_teq_trap, is_eret,
           ext_irq, status, cp0_mtc0,
    input  exception, cause, epc, eret, flush, pc_redirect, busy
  );

  modport slave (
    input  id_valid, id_pc, pipe_stall, is_syscall, is_break, is_teq_trap, is_eret,
           ext_irq, status, cp0_mtc0,
    output exception, cause, epc, eret, flush, pc_redirect, busy
  );
endinterface

// File: rtl/exception_ctrl.sv
// exception_ctrl: gates, arbitrates and issues exception/eret requests to CP0, then flushes for DRAIN_CYCLES.
// Define EXCEPTION_CTRL_IRQ_EN to add the synchronized external interrupt source.
module exception_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned XLEN    = 32;
  localparam logic [CAUSE_W-1:0] CAUSE_SYS = 5'b01000;
  localparam logic [CAUSE_W-1:0] CAUSE_BRK = 5'b01001;
  localparam logic [CAUSE_W-1:0] CAUSE_TEQ = 5'b01101;
  localparam logic [CAUSE_W-1:0] CAUSE_INT = 5'b00000;

  typedef enum logic [1:0] {IDLE, REQ_EXC, REQ_RET, DRAIN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [CAUSE_W-1:0] cause_r, cause_sel;
  logic [XLEN-1:0]    epc_r;
  logic               busy_r;
  logic               sample, sync_hit, irq_live;
  logic               take_ret, take_sync, take_irq;
  logic               irq_pending;
  logic               exc_c, ret_c, flush_c, redir_c;
  logic               unused_status;

  assign unused_status = ^bus.status[XLEN-1:5];

`ifdef EXCEPTION_CTRL_IRQ_EN
  // [0],[1] synchronize ext_irq; [2] holds the previous synchronized level for edge detect
  logic [2:0] irq_sync;
  logic       irq_rise;

  assign irq_rise = irq_sync[1] & ~irq_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_sync    <= 3'b000;
      irq_pending <= 1'b0;
    end else begin
      irq_sync    <= {irq_sync[1:0], bus.ext_irq};
      irq_pending <= (irq_pending & ~take_irq) | irq_rise;
    end
  end
`else
  logic unused_irq;

  assign irq_pending = 1'b0;
  assign unused_irq  = bus.ext_irq ^ take_irq;
`endif

  assign irq_live = irq_pending & bus.status[0] & bus.status[4];

  // Source gating and priority: eret > enabled synchronous exception > pending interrupt
  always_comb begin
    sample    = bus.id_valid & ~bus.pipe_stall & (state == IDLE);
    sync_hit  = bus.status[0] & ((bus.is_syscall  & bus.status[1]) |
                                 (bus.is_break    & bus.status[2]) |
                                 (bus.is_teq_trap & bus.status[3]));
    take_ret  = sample & bus.is_eret;
    take_sync = sample & ~bus.is_eret & sync_hit;
    take_irq  = sample & ~bus.is_eret & ~sync_hit & irq_live;
    cause_sel = CAUSE_INT;
    if (take_sync) begin
      if (bus.is_syscall)    cause_sel = CAUSE_SYS;
      else if (bus.is_break) cause_sel = CAUSE_BRK;
      else                   cause_sel = CAUSE_TEQ;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    exc_c      = 1'b0;
    ret_c      = 1'b0;
    flush_c    = 1'b0;
    redir_c    = 1'b0;
    case (state)
      IDLE: begin
        if (take_ret)                  state_next = REQ_RET;
        else if (take_sync | take_irq) state_next = REQ_EXC;
      end
      REQ_EXC, REQ_RET: begin
        // CP0 would drop a request issued alongside an mtc0, so hold it back
        if (!bus.cp0_mtc0) begin
          exc_c      = (state == REQ_EXC);
          ret_c      = (state == REQ_RET);
          flush_c    = 1'b1;
          redir_c    = 1'b1;
          cnt_next   = CNT_W'(DRAIN_CYCLES);
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        flush_c  = 1'b1;
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cause_r <= '0;
      epc_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_r <= (state_next != IDLE);
      if (take_ret | take_sync | take_irq) begin
        epc_r <= bus.id_pc;
        if (!take_ret) cause_r <= cause_sel;
      end
    end
  end

  assign bus.exception   = exc_c;
  assign bus.eret        = ret_c;
  assign bus.flush       = flush_c;
  assign bus.pc_redirect = redir_c;
  assign bus.busy        = busy_r;
  assign bus.cause       = cause_r;
  assign bus.epc         = epc_r;
endmodule
